// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-FF input synchronizer, 16x oversampling with a
// mid-bit 3-sample majority vote, and one-cycle Rx_done / Frame_error strobes.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] Baud_set,
  input  logic       Uart_rx,
  output logic [7:0] Data_byte,
  output logic       Rx_done,
  output logic       Frame_error,
  output logic       Uart_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Rounded 16x tick divisors, minus one because the counter starts at zero.
  localparam int DIV_0 = (CLK_FREQ + 8 * 9600)   / (16 * 9600)   - 1;
  localparam int DIV_1 = (CLK_FREQ + 8 * 19200)  / (16 * 19200)  - 1;
  localparam int DIV_2 = (CLK_FREQ + 8 * 38400)  / (16 * 38400)  - 1;
  localparam int DIV_3 = (CLK_FREQ + 8 * 57600)  / (16 * 57600)  - 1;
  localparam int DIV_4 = (CLK_FREQ + 8 * 115200) / (16 * 115200) - 1;

  function automatic logic [15:0] baud_div(input logic [2:0] code);
    case (code)
      3'd0:    baud_div = 16'(DIV_0);
      3'd1:    baud_div = 16'(DIV_1);
      3'd2:    baud_div = 16'(DIV_2);
      3'd3:    baud_div = 16'(DIV_3);
      default: baud_div = 16'(DIV_4);
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t      state_r, next_state_s;
  logic        sync1_r, sync2_r, sync3_r;
  logic [2:0]  baud_r;
  logic [15:0] div_cnt_r;
  logic [3:0]  samp_cnt_r;
  logic [2:0]  bit_idx_r;
  logic        v7_r, v8_r;
  logic [7:0]  shift_r;
  logic        rx_s, fall_s, tick_s, maj_s;
  logic        start_s, shift_en_s, done_s, ferr_s;

  assign rx_s   = sync2_r;
  assign fall_s = sync3_r & ~sync2_r;
  assign tick_s = (state_r != S_IDLE) && (div_cnt_r == baud_div(baud_r));
  assign maj_s  = maj3(v7_r, v8_r, rx_s);

  // Input synchronizer plus the extra flop used for falling-edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      sync3_r <= 1'b1;
    end else begin
      sync1_r <= Uart_rx;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= S_IDLE;
    else          state_r <= next_state_s;
  end

  // Next-state and per-cycle strobe decode.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    shift_en_s   = 1'b0;
    done_s       = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fall_s) begin
          next_state_s = S_START;
          start_s      = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s && (samp_cnt_r == 4'd9) && maj_s) next_state_s = S_IDLE;
        else if (tick_s && (samp_cnt_r == 4'd15))    next_state_s = S_DATA;
        else                                         next_state_s = S_START;
      end
      S_DATA: begin
        if (tick_s && (samp_cnt_r == 4'd9)) shift_en_s = 1'b1;
        else                                shift_en_s = 1'b0;
        if (tick_s && (samp_cnt_r == 4'd15) && (bit_idx_r == 3'd7)) next_state_s = S_STOP;
        else                                                        next_state_s = S_DATA;
      end
      S_STOP: begin
        // Leave at mid-stop-bit so an immediately following start edge is caught.
        if (tick_s && (samp_cnt_r == 4'd9)) begin
          next_state_s = S_IDLE;
          if (maj_s) done_s = 1'b1;
          else       ferr_s = 1'b1;
        end else begin
          next_state_s = S_STOP;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Tick divider, sample/bit counters, vote samples and shift register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      baud_r     <= 3'd0;
      div_cnt_r  <= 16'd0;
      samp_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      v7_r       <= 1'b1;
      v8_r       <= 1'b1;
      shift_r    <= 8'h00;
    end else begin
      if (start_s) baud_r <= Baud_set;
      if ((state_r == S_IDLE) || tick_s) div_cnt_r <= 16'd0;
      else                               div_cnt_r <= div_cnt_r + 16'd1;
      if (state_r == S_IDLE) samp_cnt_r <= 4'd0;
      else if (tick_s)       samp_cnt_r <= samp_cnt_r + 4'd1;
      if (state_r != S_DATA)                        bit_idx_r <= 3'd0;
      else if (tick_s && (samp_cnt_r == 4'd15))     bit_idx_r <= bit_idx_r + 3'd1;
      if (tick_s && (samp_cnt_r == 4'd7)) v7_r <= rx_s;
      if (tick_s && (samp_cnt_r == 4'd8)) v8_r <= rx_s;
      if (shift_en_s) shift_r[bit_idx_r] <= maj_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_byte   <= 8'h00;
      Rx_done     <= 1'b0;
      Frame_error <= 1'b0;
      Uart_state  <= 1'b0;
    end else begin
      Rx_done     <= done_s;
      Frame_error <= ferr_s;
      Uart_state  <= (next_state_s != S_IDLE);
      if (done_s) Data_byte <= shift_r;
    end
  end

endmodule
